game_status_ctrl: RTL



---
 rtl/game_status_ctrl_pkg.sv | 16 +
 rtl/game_status_ctrl_if.sv | 24 ++
 rtl/game_status_ctrl_frame_timer.sv | 18 +
 rtl/game_status_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/game_status_ctrl_pkg.sv
// game_pkg: game-phase encodings, lives width and maze dot defaults shared with the dot ROM
package game_pkg;
    localparam int LIVES_W       = 3;
    localparam int DEF_NUM_PDOTS = 240;
    localparam int DEF_NUM_EDOTS = 4;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READY   = 3'd1,
        PLAYING = 3'd2,
        DYING   = 3'd3,
        OVER    = 3'd4
    } game_state_e;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/game_status_ctrl_if.sv
// game_status_ctrl_if: keypad/collision events in, overlay and sprite-mover status out
interface game_status_ctrl_if;
    import game_pkg::*;
    logic               start_key;
    logic               frame_tick;
    logic               pdot_eaten;
    logic               edot_eaten;
    logic               pacman_hit;
    logic               game_started;
    logic               pdot_exist;
    logic               edot_exist;
    logic [LIVES_W-1:0] lives;
    logic               frozen;
    logic               restart_level;
    logic [2:0]         state_dbg;
    modport master (
        output start_key, frame_tick, pdot_eaten, edot_eaten, pacman_hit,
        input  game_started, pdot_exist, edot_exist, lives, frozen, restart_level, state_dbg
    );
    modport slave (
        input  start_key, frame_tick, pdot_eaten, edot_eaten, pacman_hit,
        output game_started, pdot_exist, edot_exist, lives, frozen, restart_level, state_dbg
    );
endinterface

// File: rtl/game_status_ctrl_frame_timer.sv
// frame_timer: counts frame ticks from a cleared start and flags the tick that reaches TC
module frame_timer #(
    parameter int TC = 60,
    parameter int W  = $clog2(TC + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_tick,
    output logic o_done
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset || i_load) r_cnt <= '0;
        else if (i_tick) r_cnt <= r_cnt + 1'b1;
    end
    assign o_done = i_tick && (r_cnt == W'(TC - 1));
endmodule

// File: rtl/game_status_ctrl.sv
// game_status_ctrl: game-phase FSM, lives and dot counters feeding the finish-screen overlay.
// GAME_STATUS_EXTRA_LIFE_EN: one bonus life when remaining pellets first reach EXTRA_LIFE_AT.
module game_status_ctrl
    import game_pkg::*;
#(
    parameter int START_LIVES        = 3,
    parameter int MAX_LIVES          = 7,
    parameter int NUM_PDOTS          = DEF_NUM_PDOTS,
    parameter int NUM_EDOTS          = DEF_NUM_EDOTS,
    parameter int START_DELAY_FRAMES = 60,
    parameter int DEATH_HOLD_FRAMES  = 120,
    parameter int EXTRA_LIFE_AT      = 120
) (
    input logic               clk,
    input logic               reset,
    game_status_ctrl_if.slave bus
);
    localparam int PW = $clog2(NUM_PDOTS + 1);
    localparam int EW = $clog2(NUM_EDOTS + 1);
    localparam int FW = $clog2(max2(START_DELAY_FRAMES, DEATH_HOLD_FRAMES) + 1);
`ifdef GAME_STATUS_EXTRA_LIFE_EN
    localparam bit EL_EN = 1'b1;
`else
    localparam bit EL_EN = 1'b0;
`endif

    game_state_e        r_state, w_state_n;
    logic [PW-1:0]      r_pd, w_pd_n;
    logic [EW-1:0]      r_ed, w_ed_n;
    logic [LIVES_W-1:0] r_lives, w_lives_n;
    logic               r_key_prev, r_started, r_frozen, r_restart, r_armed;
    logic               w_start, w_win, w_hit, w_award, w_ready_done, w_dying_done;

    frame_timer #(.TC(START_DELAY_FRAMES), .W(FW)) u_ready_timer (
        .clk(clk), .reset(reset), .i_load(r_state != READY),
        .i_tick(bus.frame_tick), .o_done(w_ready_done)
    );
    frame_timer #(.TC(DEATH_HOLD_FRAMES), .W(FW)) u_dying_timer (
        .clk(clk), .reset(reset), .i_load(r_state != DYING),
        .i_tick(bus.frame_tick), .o_done(w_dying_done)
    );

    assign w_start = bus.start_key && !r_key_prev;

    always_comb begin
        w_state_n = r_state;
        w_pd_n    = r_pd;
        w_ed_n    = r_ed;
        w_lives_n = r_lives;
        w_win     = 1'b0;
        w_hit     = 1'b0;
        w_award   = 1'b0;
        case (r_state)
            IDLE:    w_state_n = w_start ? READY : IDLE;
            READY:   w_state_n = w_ready_done ? PLAYING : READY;
            PLAYING: begin
                w_pd_n    = (bus.pdot_eaten && r_pd != '0) ? r_pd - 1'b1 : r_pd;
                w_ed_n    = (bus.edot_eaten && r_ed != '0) ? r_ed - 1'b1 : r_ed;
                w_win     = (w_pd_n == '0) && (w_ed_n == '0);
                w_hit     = bus.pacman_hit && !w_win;
                w_award   = EL_EN && r_armed && (w_pd_n != r_pd) && (int'(w_pd_n) <= EXTRA_LIFE_AT);
                // a bonus and a hit in one cycle cancel out
                w_lives_n = (w_award && !w_hit && r_lives != LIVES_W'(MAX_LIVES)) ? r_lives + 1'b1
                          : (w_hit && !w_award && r_lives != '0) ? r_lives - 1'b1 : r_lives;
                w_state_n = w_win ? OVER : w_hit ? DYING : PLAYING;
            end
            DYING:   w_state_n = !w_dying_done ? DYING : (r_lives == '0) ? OVER : READY;
            default: w_state_n = r_state;
        endcase
    end

    // the key history keeps sampling through reset so a held key never counts as a fresh press
    always_ff @(posedge clk) begin
        r_key_prev <= bus.start_key;
        if (reset) begin
            r_state   <= IDLE;
            r_pd      <= PW'(NUM_PDOTS);
            r_ed      <= EW'(NUM_EDOTS);
            r_lives   <= LIVES_W'(START_LIVES);
            r_started <= 1'b0;
            r_frozen  <= 1'b1;
            r_restart <= 1'b0;
            r_armed   <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_pd      <= w_pd_n;
            r_ed      <= w_ed_n;
            r_lives   <= w_lives_n;
            r_started <= r_started || (r_state == IDLE && w_start);
            r_frozen  <= w_state_n != PLAYING;
            r_restart <= (r_state == DYING) && (w_state_n == READY);
            r_armed   <= r_armed && !w_award;
        end
    end

    assign bus.game_started  = r_started;
    assign bus.pdot_exist    = r_pd != '0;
    assign bus.edot_exist    = r_ed != '0;
    assign bus.lives         = r_lives;
    assign bus.frozen        = r_frozen;
    assign bus.restart_level = r_restart;
    assign bus.state_dbg     = r_state;
endmodule
